// File: rtl/stft_framer_if.sv
// Sample-in / frame-out stream bundle for the STFT framer.
// The framer is the master: it takes in the strobed samples and drives the frame stream.
interface stft_framer_if #(
   parameter int WL = 12,
   parameter int LN = 4
);
   logic          iEN;
   logic [WL-1:0] iDATA;
   logic          iREADY;
   logic          oVALID;
   logic [WL-1:0] oDATA;
   logic [LN-1:0] oIDX;
   logic          oSOF;
   logic          oEOF;
   logic          oOVF;

   modport master (
      input  iEN, iDATA, iREADY,
      output oVALID, oDATA, oIDX, oSOF, oEOF, oOVF
   );

   modport slave (
      output iEN, iDATA, iREADY,
      input  oVALID, oDATA, oIDX, oSOF, oEOF, oOVF
   );
endinterface

// File: rtl/stft_framer.sv
// Collects strobed ADC samples in a 2N-deep circular buffer and streams the latest N
// samples as one overlapping STFT frame every HOP samples, with a one-deep pending slot.
module stft_framer #(
   parameter int WL  = 12,
   parameter int N   = 16,
   parameter int LN  = 4,
   parameter int HOP = 8
) (
   input logic           iCLK,
   input logic           iRST,
   stft_framer_if.master bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   localparam int             DEPTH    = 2 * N;
   localparam logic [LN:0]    FULL     = (LN + 1)'(N);
   localparam logic [LN:0]    FULL_M1  = (LN + 1)'(N - 1);
   localparam logic [LN-1:0]  HOP_LAST = LN'(HOP - 1);
   localparam logic [LN-1:0]  IDX_LAST = LN'(N - 1);

   logic [WL-1:0] bufR [DEPTH];
   logic [LN:0]   wpR;
   logic [LN:0]   fillR;
   logic [LN-1:0] hopR;
   logic [LN-1:0] idxR;
   logic [LN:0]   baseR;
   logic [LN:0]   pendBaseR;
   logic          pendR;
   logic          ovfR;
   state_t        stateR;

   logic          trigS;
   logic          doneS;
   logic [LN:0]   trigBaseS;
   logic [LN:0]   rdAddrS;

   // Trigger detection, frame-base arithmetic (wraps modulo 2N) and read address
   always_comb begin
      trigS     = 1'b0;
      trigBaseS = wpR + (LN + 1)'(1) - FULL;
      rdAddrS   = baseR + {1'b0, idxR};
      doneS     = (stateR == SEND) && bus.iREADY && (idxR == IDX_LAST);
      if (bus.iEN) begin
         if (fillR == FULL_M1) begin
            trigS = 1'b1;
         end else if ((fillR == FULL) && (hopR == HOP_LAST)) begin
            trigS = 1'b1;
         end else begin
            trigS = 1'b0;
         end
      end else begin
         trigS = 1'b0;
      end
   end

   // Write pointer, fill and hop counters; hop only runs once the buffer holds N samples
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         wpR   <= '0;
         fillR <= '0;
         hopR  <= '0;
      end else if (bus.iEN) begin
         wpR <= wpR + (LN + 1)'(1);
         if (fillR != FULL) begin
            fillR <= fillR + (LN + 1)'(1);
         end else if (hopR == HOP_LAST) begin
            hopR <= '0;
         end else begin
            hopR <= hopR + LN'(1);
         end
      end
   end

   // Sample buffer; contents are left untouched by reset
   always_ff @(posedge iCLK) begin
      if (bus.iEN && !iRST) begin
         bufR[wpR] <= bus.iDATA;
      end
   end

   // Frame sequencer with one-deep pending slot and overflow pulse
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         stateR    <= IDLE;
         baseR     <= '0;
         idxR      <= '0;
         pendR     <= 1'b0;
         pendBaseR <= '0;
         ovfR      <= 1'b0;
      end else begin
         ovfR <= 1'b0;
         case (stateR)
            IDLE: begin
               if (trigS) begin
                  stateR <= SEND;
                  baseR  <= trigBaseS;
                  idxR   <= '0;
               end
            end
            SEND: begin
               if (doneS) begin
                  idxR <= '0;
                  // A coincident trigger queues behind the pending frame instead of overflowing
                  if (pendR) begin
                     baseR <= pendBaseR;
                     if (trigS) begin
                        pendBaseR <= trigBaseS;
                     end else begin
                        pendR <= 1'b0;
                     end
                  end else if (trigS) begin
                     baseR <= trigBaseS;
                  end else begin
                     stateR <= IDLE;
                  end
               end else begin
                  if (bus.iREADY) begin
                     idxR <= idxR + LN'(1);
                  end
                  if (trigS) begin
                     if (!pendR) begin
                        pendR     <= 1'b1;
                        pendBaseR <= trigBaseS;
                     end else begin
                        ovfR <= 1'b1;
                     end
                  end
               end
            end
            default: stateR <= IDLE;
         endcase
      end
   end

   assign bus.oVALID = (stateR == SEND);
   assign bus.oDATA  = (stateR == SEND) ? bufR[rdAddrS] : '0;
   assign bus.oIDX   = (stateR == SEND) ? idxR : '0;
   assign bus.oSOF   = (stateR == SEND) && (idxR == '0);
   assign bus.oEOF   = (stateR == SEND) && (idxR == IDX_LAST);
   assign bus.oOVF   = ovfR;
endmodule

// File: tb/tb_stft_framer.sv
// Directed bench for stft_framer: overlap, backpressure, pending/overflow, mid-frame reset
// (HOP=8 instance) and disjoint frames (HOP=N instance).
module tb_stft_framer;
   logic iCLK = 1'b0;
   logic rstA = 1'b1;
   logic rstB = 1'b1;
   int   cyc  = 0;
   int   checkCnt = 0;
   int   errCnt   = 0;
   int   ovfA = 0;
   int   ovfB = 0;

   typedef struct {
      logic [11:0] d;
      logic [3:0]  i;
      logic        s;
      logic        e;
      int          c;
   } word_t;
   word_t words[$];

   stft_framer_if #(.WL(12), .LN(4)) aIf ();
   stft_framer_if #(.WL(12), .LN(4)) bIf ();

   stft_framer #(.WL(12), .N(16), .LN(4), .HOP(8)) dutA (
      .iCLK(iCLK), .iRST(rstA), .bus(aIf)
   );
   stft_framer #(.WL(12), .N(16), .LN(4), .HOP(16)) dutB (
      .iCLK(iCLK), .iRST(rstB), .bus(bIf)
   );

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) cyc <= cyc + 1;

   // Record every accepted word of either instance plus overflow pulses
   always @(negedge iCLK) begin
      if (!rstA && aIf.oVALID && aIf.iREADY)
         words.push_back('{aIf.oDATA, aIf.oIDX, aIf.oSOF, aIf.oEOF, cyc});
      if (!rstB && bIf.oVALID && bIf.iREADY)
         words.push_back('{bIf.oDATA, bIf.oIDX, bIf.oSOF, bIf.oEOF, cyc});
      if (aIf.oOVF) ovfA++;
      if (bIf.oOVF) ovfB++;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic waitWords(input int target, input int budget);
      int t = 0;
      while (words.size() < target && t < budget) begin
         tick();
         t++;
      end
      repeat (4) tick();
   endtask

   // mode 0: no timing check, 1: contiguous within a frame, 2: contiguous across frames too
   task automatic verifyStream(input string tag, input int start, input int nFr,
                               input int f0, input int f1, input int f2, input int mode);
      int firsts[3];
      int k;
      logic [31:0] expW;
      logic [31:0] obsW;
      firsts = '{f0, f1, f2};
      checkVal({tag, "_len"}, words.size() - start, nFr * 16);
      if (words.size() - start == nFr * 16) begin
         for (int f = 0; f < nFr; f++) begin
            for (int i = 0; i < 16; i++) begin
               k = start + f * 16 + i;
               obsW = {14'd0, words[k].d, words[k].i, words[k].s, words[k].e};
               expW = {14'd0, 12'(firsts[f] + i), 4'(i), (i == 0), (i == 15)};
               checkVal($sformatf("%s_f%0d_w%0d", tag, f, i), obsW, expW);
               if ((mode == 1 && i > 0) || (mode == 2 && k > start))
                  checkVal($sformatf("%s_gap%0d", tag, k - start), words[k].c, words[k-1].c + 1);
            end
         end
      end
   endtask

   initial begin
      int w0;
      int t;
      int oBase;
      int eofs;
      aIf.iEN = 1'b0; aIf.iDATA = '0; aIf.iREADY = 1'b1;
      bIf.iEN = 1'b0; bIf.iDATA = '0; bIf.iREADY = 1'b1;

      // Reset state
      tick(); tick();
      @(negedge iCLK);
      checkVal("rst_valid", aIf.oVALID, 0);
      checkVal("rst_sof", aIf.oSOF, 0);
      checkVal("rst_eof", aIf.oEOF, 0);
      checkVal("rst_ovf", aIf.oOVF, 0);
      checkVal("rst_data", aIf.oDATA, 0);
      checkVal("rst_idx", aIf.oIDX, 0);
      rstA = 1'b0;

      // First frame and overlapping frames, one sample every 4 cycles
      w0 = words.size();
      for (int v = 1; v <= 32; v++) begin
         aIf.iEN = 1'b1; aIf.iDATA = 12'(v);
         tick();
         aIf.iEN = 1'b0;
         if (v == 15) begin
            @(negedge iCLK);
            checkVal("pre_first_valid", aIf.oVALID, 0);
         end
         if (v == 16) begin
            @(negedge iCLK);
            checkVal("first_sof", aIf.oSOF, 1);
            checkVal("first_data", aIf.oDATA, 1);
            checkVal("first_idx", aIf.oIDX, 0);
         end
         repeat (3) tick();
      end
      waitWords(w0 + 48, 60);
      verifyStream("overlap", w0, 3, 1, 9, 17, 1);

      // Backpressure mid-frame at index 6 (frame 25..40)
      w0 = words.size();
      for (int v = 33; v <= 40; v++) begin
         aIf.iEN = 1'b1; aIf.iDATA = 12'(v);
         tick();
      end
      aIf.iEN = 1'b0;
      t = 0;
      while (!(aIf.oVALID && aIf.oIDX == 4'd6) && t < 20) begin
         tick();
         t++;
      end
      aIf.iREADY = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge iCLK);
         checkVal($sformatf("stall_idx%0d", s), aIf.oIDX, 6);
         checkVal($sformatf("stall_data%0d", s), aIf.oDATA, 31);
         tick();
      end
      aIf.iREADY = 1'b1;
      tick();
      @(negedge iCLK);
      checkVal("resume_idx", aIf.oIDX, 7);
      checkVal("resume_data", aIf.oDATA, 32);
      waitWords(w0 + 16, 40);
      verifyStream("bp", w0, 1, 25, 0, 0, 0);

      // Pending and overflow with a sample every cycle and the sink stalled
      rstA = 1'b1;
      tick();
      rstA = 1'b0;
      aIf.iREADY = 1'b0;
      oBase = ovfA;
      w0 = words.size();
      for (int v = 1; v <= 32; v++) begin
         aIf.iEN = 1'b1; aIf.iDATA = 12'(v);
         tick();
         @(negedge iCLK);
         if (v == 16) begin
            checkVal("pend_a_valid", aIf.oVALID, 1);
            checkVal("pend_a_data", aIf.oDATA, 1);
         end
         if (v == 24) checkVal("pend_no_ovf", aIf.oOVF, 0);
         if (v == 32) checkVal("ovf_pulse", aIf.oOVF, 1);
      end
      aIf.iEN = 1'b0;
      tick();
      @(negedge iCLK);
      checkVal("ovf_one_cycle", aIf.oOVF, 0);
      checkVal("pend_stalled_idx", aIf.oIDX, 0);
      tick();
      aIf.iREADY = 1'b1;
      waitWords(w0 + 32, 60);
      verifyStream("pend", w0, 2, 1, 9, 0, 2);
      checkVal("ovf_count", ovfA - oBase, 1);

      // Reset in the middle of a frame
      rstA = 1'b1;
      tick();
      rstA = 1'b0;
      w0 = words.size();
      for (int v = 1; v <= 16; v++) begin
         aIf.iEN = 1'b1; aIf.iDATA = 12'(v);
         tick();
      end
      aIf.iEN = 1'b0;
      t = 0;
      while (!(aIf.oVALID && aIf.oIDX == 4'd9) && t < 20) begin
         tick();
         t++;
      end
      rstA = 1'b1;
      aIf.iEN = 1'b1; aIf.iDATA = 12'd77;
      tick();
      rstA = 1'b0;
      aIf.iEN = 1'b0;
      @(negedge iCLK);
      checkVal("midrst_valid", aIf.oVALID, 0);
      checkVal("midrst_ovf", aIf.oOVF, 0);
      eofs = 0;
      for (int k = w0; k < words.size(); k++) if (words[k].e) eofs++;
      checkVal("midrst_no_eof", eofs, 0);
      checkVal("midrst_words", words.size() - w0, 9);
      w0 = words.size();
      for (int v = 101; v <= 116; v++) begin
         aIf.iEN = 1'b1; aIf.iDATA = 12'(v);
         tick();
         aIf.iEN = 1'b0;
         if (v == 115) begin
            @(negedge iCLK);
            checkVal("postrst_not_yet", aIf.oVALID, 0);
         end
         if (v == 116) begin
            @(negedge iCLK);
            checkVal("postrst_sof", aIf.oSOF, 1);
            checkVal("postrst_data", aIf.oDATA, 101);
         end
         tick();
      end
      waitWords(w0 + 16, 40);
      verifyStream("postrst", w0, 1, 101, 0, 0, 1);

      // HOP = N: disjoint frames, no overflow at half rate
      tick();
      rstB = 1'b0;
      oBase = ovfB;
      w0 = words.size();
      for (int v = 1; v <= 32; v++) begin
         bIf.iEN = 1'b1; bIf.iDATA = 12'(v);
         tick();
         bIf.iEN = 1'b0;
         tick();
      end
      waitWords(w0 + 32, 40);
      verifyStream("hopn", w0, 2, 1, 17, 0, 1);
      checkVal("hopn_no_ovf", ovfB - oBase, 0);

      $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
      $finish;
   end
endmodule
